// File: rtl/pc_sp_sequencer_if.sv
// Bundle between the instruction decoder / pointer registers / stack RAM and
// the PC/SP sequencer. The master side issues requests and owns the pointers and RAM.
interface pc_sp_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req;
  logic [2:0]       op;
  logic [WIDTH-1:0] arg;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] sp_in;

  logic             pc_inc;
  logic             pc_write;
  logic [WIDTH-1:0] pc_newv;
  logic             sp_inc;
  logic             sp_dec;
  logic             sp_write;
  logic [WIDTH-1:0] sp_newv;

  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_we;
  logic             mem_re;

  logic             ready;
  logic             done;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [WIDTH-1:0] result;

  modport master (
    output req, op, arg, pc_in, sp_in, mem_rdata,
    input  pc_inc, pc_write, pc_newv, sp_inc, sp_dec, sp_write, sp_newv,
           mem_addr, mem_wdata, mem_we, mem_re,
           ready, done, fault, fault_cause, result
  );

  modport slave (
    input  req, op, arg, pc_in, sp_in, mem_rdata,
    output pc_inc, pc_write, pc_newv, sp_inc, sp_dec, sp_write, sp_newv,
           mem_addr, mem_wdata, mem_we, mem_re,
           ready, done, fault, fault_cause, result
  );
endinterface

// File: rtl/pc_sp_sequencer.sv
// Turns single control-flow requests into PC/SP pointer strobes and stack RAM
// cycles, with overflow/underflow checks on the stack region.
module pc_sp_sequencer #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(32'h0000_F000),
  parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(32'h0000_FFFF)
) (
  input logic            clk,
  input logic            rst_n,
  pc_sp_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MEMW, MEMR, WAIT, UPD, FIN} state_t;
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_CALL = 3'd2, OP_RET = 3'd3,
    OP_PUSH = 3'd4, OP_POP  = 3'd5, OP_ILL6 = 3'd6, OP_ILL7 = 3'd7
  } op_t;

  state_t           state, next_state;
  op_t              op_in, op_q;
  logic [WIDTH-1:0] arg_q, pc_q, sp_q, result_q;
  logic             fault_q;
  logic [1:0]       cause_q, accept_cause;
  logic             accept;

  always_comb begin
    op_in        = op_t'(bus.op);
    accept       = (state == IDLE) && bus.req;
    accept_cause = 2'b00;
    case (op_in)
      OP_PUSH, OP_CALL: if (bus.sp_in == STACK_LIMIT) accept_cause = 2'b01;
      OP_POP,  OP_RET:  if (bus.sp_in == STACK_BASE)  accept_cause = 2'b10;
      OP_ILL6, OP_ILL7: accept_cause = 2'b11;
      default:          accept_cause = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Operands are snapshotted at accept so pointer updates mid-operation cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_NEXT;
      arg_q    <= '0;
      pc_q     <= '0;
      sp_q     <= '0;
      fault_q  <= 1'b0;
      cause_q  <= 2'b00;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        arg_q   <= bus.arg;
        pc_q    <= bus.pc_in;
        sp_q    <= bus.sp_in;
        fault_q <= (accept_cause != 2'b00);
        cause_q <= accept_cause;
      end
      if (state == WAIT) result_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (accept_cause != 2'b00) next_state = FIN;
          else begin
            case (op_in)
              OP_NEXT, OP_JUMP: next_state = UPD;
              OP_PUSH, OP_CALL: next_state = MEMW;
              OP_POP,  OP_RET:  next_state = MEMR;
              default:          next_state = FIN;
            endcase
          end
        end
      end
      MEMW:    next_state = UPD;
      MEMR:    next_state = WAIT;
      WAIT:    next_state = UPD;
      UPD:     next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Everything below is decoded from state and the latched operands only.
  always_comb begin
    bus.pc_inc      = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_newv     = '0;
    bus.sp_inc      = 1'b0;
    bus.sp_dec      = 1'b0;
    bus.sp_write    = 1'b0;
    bus.sp_newv     = '0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_we      = 1'b0;
    bus.mem_re      = 1'b0;
    bus.ready       = (state == IDLE);
    bus.done        = (state == FIN);
    bus.fault       = fault_q;
    bus.fault_cause = cause_q;
    bus.result      = result_q;
    case (state)
      MEMW: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_q;
        bus.mem_wdata = (op_q == OP_CALL) ? pc_q + WIDTH'(1) : arg_q;
      end
      MEMR: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = sp_q - WIDTH'(1);
      end
      UPD: begin
        case (op_q)
          OP_NEXT: bus.pc_inc = 1'b1;
          OP_JUMP: begin
            bus.pc_write = 1'b1;
            bus.pc_newv  = arg_q;
          end
          OP_CALL: begin
            bus.sp_inc   = 1'b1;
            bus.pc_write = 1'b1;
            bus.pc_newv  = arg_q;
          end
          OP_RET: begin
            bus.sp_dec   = 1'b1;
            bus.pc_write = 1'b1;
            bus.pc_newv  = result_q;
          end
          OP_PUSH: bus.sp_inc = 1'b1;
          OP_POP:  bus.sp_dec = 1'b1;
          default: bus.pc_inc = 1'b0;
        endcase
      end
      default: bus.ready = (state == IDLE);
    endcase
  end

endmodule

// File: tb/tb_pc_sp_sequencer.sv
// Randomized bench for pc_sp_sequencer: the bench plays the PC/SP registers and
// stack RAM and compares each request against a stack-machine reference model.
module tb_pc_sp_sequencer;

  localparam logic [31:0] BASE  = 32'h0000_F000;
  localparam logic [31:0] LIMIT = 32'h0000_FFFF;
  localparam int          DEPTH = 4096;

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_CALL = 3'd2,
                         OP_RET  = 3'd3, OP_PUSH = 3'd4, OP_POP  = 3'd5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sp_sequencer_if #(.WIDTH(32)) bus ();

  pc_sp_sequencer #(
    .WIDTH      (32),
    .STACK_BASE (BASE),
    .STACK_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] pc_reg        = 32'h0;
  logic [31:0] sp_reg        = BASE;
  logic [31:0] mem_rdata_q   = 32'h0;
  logic        ram_init_done = 1'b0;
  logic        preload_req   = 1'b0;
  logic [31:0] preload_pc    = 32'h0;
  logic [31:0] preload_sp    = BASE;
  logic [31:0] ram [0:DEPTH-1];

  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_sp     = BASE;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_ram [0:DEPTH-1];

  assign bus.pc_in     = pc_reg;
  assign bus.sp_in     = sp_reg;
  assign bus.mem_rdata = mem_rdata_q;

  function automatic logic [31:0] seedWord(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [11:0] ramIdx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[11:0];
  endfunction

  function automatic bit inStack(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  // Pointer registers and stack RAM as the decoder's world would hold them.
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seedWord(i);
      ram_init_done <= 1'b1;
    end
    if (preload_req) begin
      pc_reg <= preload_pc;
      sp_reg <= preload_sp;
    end else begin
      if (bus.pc_write)    pc_reg <= bus.pc_newv;
      else if (bus.pc_inc) pc_reg <= pc_reg + 32'd1;
      if (bus.sp_inc)      sp_reg <= sp_reg + 32'd1;
      else if (bus.sp_dec) sp_reg <= sp_reg - 32'd1;
      if (bus.mem_we && inStack(bus.mem_addr)) ram[ramIdx(bus.mem_addr)] <= bus.mem_wdata;
    end
    mem_rdata_q <= (bus.mem_re && inStack(bus.mem_addr)) ? ram[ramIdx(bus.mem_addr)] : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic setPointers(input logic [31:0] pc_v, input logic [31:0] sp_v);
    @(negedge clk);
    preload_pc  = pc_v;
    preload_sp  = sp_v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    m_pc = pc_v;
    m_sp = sp_v;
  endtask

  task automatic applyStimulus(input logic [2:0] op_v, input logic [31:0] arg_v, input bit hold_req);
    logic [1:0]  e_cause;
    int          e_lat, e_inc, e_wr, e_spi, e_spd, e_we, e_re;
    logic [31:0] e_newv, e_addr, e_wdata, e_raddr, top;
    int          n_done, done_cyc, n_inc, c_inc, n_wr, c_wr, n_spi, c_spi, n_spd, c_spd;
    int          n_we, c_we, n_re, c_re, clash, busy_ready, stray, cyc;
    logic [31:0] g_newv, g_addr, g_wdata, g_raddr;
    logic        g_fault;
    logic [1:0]  g_cause;

    e_cause = 2'b00;
    if (op_v >= 3'd6) e_cause = 2'b11;
    else if ((op_v == OP_PUSH || op_v == OP_CALL) && m_sp == LIMIT) e_cause = 2'b01;
    else if ((op_v == OP_POP  || op_v == OP_RET)  && m_sp == BASE)  e_cause = 2'b10;

    e_lat = 1; e_inc = 0; e_wr = 0; e_spi = 0; e_spd = 0; e_we = 0; e_re = 0;
    e_newv = 0; e_addr = 0; e_wdata = 0; e_raddr = 0;
    top = m_sp - 32'd1;
    if (e_cause == 2'b00) begin
      case (op_v)
        OP_NEXT: begin e_lat = 2; e_inc = 1; end
        OP_JUMP: begin e_lat = 2; e_wr = 1; e_newv = arg_v; end
        OP_PUSH: begin e_lat = 3; e_we = 1; e_addr = m_sp; e_wdata = arg_v; e_spi = 2; end
        OP_CALL: begin
          e_lat = 3; e_we = 1; e_addr = m_sp; e_wdata = m_pc + 32'd1;
          e_spi = 2; e_wr = 2; e_newv = arg_v;
        end
        OP_POP:  begin e_lat = 4; e_re = 1; e_raddr = top; e_spd = 3; end
        default: begin
          e_lat = 4; e_re = 1; e_raddr = top; e_spd = 3; e_wr = 3;
          e_newv = m_ram[ramIdx(top)];
        end
      endcase
    end

    @(negedge clk);
    checkOutput("ready_before_req", 32'(bus.ready), 32'd1);
    bus.req = 1'b1;
    bus.op  = op_v;
    bus.arg = arg_v;
    @(posedge clk);

    n_done = 0; done_cyc = 0; n_inc = 0; c_inc = 0; n_wr = 0; c_wr = 0;
    n_spi = 0; c_spi = 0; n_spd = 0; c_spd = 0; n_we = 0; c_we = 0; n_re = 0; c_re = 0;
    clash = 0; busy_ready = 0; stray = 0;
    g_newv = 0; g_addr = 0; g_wdata = 0; g_raddr = 0; g_fault = 0; g_cause = 0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.pc_inc)   begin n_inc++; c_inc = cyc; end
      if (bus.pc_write) begin n_wr++;  c_wr = cyc; g_newv = bus.pc_newv; end
      if (bus.sp_inc)   begin n_spi++; c_spi = cyc; end
      if (bus.sp_dec)   begin n_spd++; c_spd = cyc; end
      if (bus.mem_we)   begin n_we++;  c_we = cyc; g_addr = bus.mem_addr; g_wdata = bus.mem_wdata; end
      if (bus.mem_re)   begin n_re++;  c_re = cyc; g_raddr = bus.mem_addr; end
      if ((bus.pc_inc && bus.pc_write) || (bus.sp_inc && bus.sp_dec)) clash++;
      if (bus.sp_write || bus.sp_newv != 0) stray++;
      if (!bus.pc_write && bus.pc_newv != 0) stray++;
      if (!bus.mem_we && !bus.mem_re && (bus.mem_addr != 0 || bus.mem_wdata != 0)) stray++;
      if (n_done == 0 && bus.ready) busy_ready++;
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          g_fault  = bus.fault;
          g_cause  = bus.fault_cause;
        end
      end
      if (!hold_req) bus.req = 1'b0;
      else if (bus.done) bus.req = 1'b0;
      if (done_cyc != 0 && (!hold_req || cyc >= done_cyc + 3)) break;
    end
    bus.req = 1'b0;

    if (e_cause == 2'b00 && (op_v == OP_POP || op_v == OP_RET)) m_result = m_ram[ramIdx(top)];

    checkOutput("done_cycle", 32'(done_cyc), 32'(e_lat));
    checkOutput("done_count", 32'(n_done), 32'd1);
    checkOutput("fault", 32'(g_fault), 32'(e_cause != 2'b00));
    checkOutput("fault_cause", 32'(g_cause), 32'(e_cause));
    checkOutput("busy_ready", 32'(busy_ready), 32'd0);
    checkOutput("strobe_clash", 32'(clash), 32'd0);
    checkOutput("stray_output", 32'(stray), 32'd0);
    checkOutput("pc_inc_cycle", 32'(c_inc), 32'(e_inc));
    checkOutput("pc_inc_count", 32'(n_inc), 32'(e_inc != 0));
    checkOutput("pc_write_cycle", 32'(c_wr), 32'(e_wr));
    checkOutput("pc_write_count", 32'(n_wr), 32'(e_wr != 0));
    checkOutput("pc_newv", g_newv, e_newv);
    checkOutput("sp_inc_cycle", 32'(c_spi), 32'(e_spi));
    checkOutput("sp_inc_count", 32'(n_spi), 32'(e_spi != 0));
    checkOutput("sp_dec_cycle", 32'(c_spd), 32'(e_spd));
    checkOutput("sp_dec_count", 32'(n_spd), 32'(e_spd != 0));
    checkOutput("mem_we_cycle", 32'(c_we), 32'(e_we));
    checkOutput("mem_we_count", 32'(n_we), 32'(e_we != 0));
    checkOutput("mem_waddr", g_addr, e_addr);
    checkOutput("mem_wdata", g_wdata, e_wdata);
    checkOutput("mem_re_cycle", 32'(c_re), 32'(e_re));
    checkOutput("mem_re_count", 32'(n_re), 32'(e_re != 0));
    checkOutput("mem_raddr", g_raddr, e_raddr);
    checkOutput("result", bus.result, m_result);

    if (e_cause == 2'b00) begin
      case (op_v)
        OP_NEXT: m_pc = m_pc + 32'd1;
        OP_JUMP: m_pc = arg_v;
        OP_PUSH: begin m_ram[ramIdx(m_sp)] = arg_v; m_sp = m_sp + 32'd1; end
        OP_CALL: begin m_ram[ramIdx(m_sp)] = m_pc + 32'd1; m_sp = m_sp + 32'd1; m_pc = arg_v; end
        OP_POP:  m_sp = top;
        default: begin m_sp = top; m_pc = m_result; end
      endcase
    end
    checkOutput("pc_after", pc_reg, m_pc);
    checkOutput("sp_after", sp_reg, m_sp);
    if (e_we != 0) checkOutput("ram_word", ram[ramIdx(e_addr)], e_wdata);
  endtask

  task automatic resetMidPop();
    logic [31:0] sp_before;
    setPointers(m_pc, BASE + 32'd5);
    sp_before = m_sp;
    @(negedge clk);
    bus.req = 1'b1;
    bus.op  = OP_POP;
    bus.arg = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(bus.ready), 32'd1);
    checkOutput("rst_strobes", 32'({bus.pc_inc, bus.pc_write, bus.sp_inc, bus.sp_dec, bus.sp_write}), 32'd0);
    checkOutput("rst_mem", 32'({bus.mem_we, bus.mem_re, bus.done, bus.fault, bus.fault_cause}), 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_sp_held", sp_reg, sp_before);
    rst_n    = 1'b1;
    m_result = 32'h0;
    @(negedge clk);
    checkOutput("rst_ready_after", 32'(bus.ready), 32'd1);
    checkOutput("rst_sp_after", sp_reg, sp_before);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0]  op_r;
    logic [31:0] sp_r;
    int          r;
    bus.req = 1'b0;
    bus.op  = 3'd0;
    bus.arg = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_ram[i] = seedWord(i);

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(bus.ready), 32'd1);
    checkOutput("reset_flags", 32'({bus.done, bus.fault, bus.fault_cause}), 32'd0);
    checkOutput("reset_strobes", 32'({bus.pc_inc, bus.pc_write, bus.sp_inc, bus.sp_dec, bus.mem_we, bus.mem_re}), 32'd0);
    checkOutput("reset_result", bus.result, 32'd0);
    rst_n = 1'b1;

    setPointers(32'd5, BASE);
    applyStimulus(OP_NEXT, 32'h0, 1'b0);
    applyStimulus(OP_PUSH, 32'hAB, 1'b0);
    setPointers(32'h20, BASE + 32'd1);
    applyStimulus(OP_CALL, 32'h100, 1'b0);
    applyStimulus(OP_RET, 32'h0, 1'b0);
    checkOutput("ret_result_0x21", bus.result, 32'h21);
    setPointers(32'h40, BASE);
    applyStimulus(OP_POP, 32'h0, 1'b0);
    setPointers(32'h40, LIMIT);
    applyStimulus(OP_PUSH, 32'h55, 1'b0);
    applyStimulus(OP_CALL, 32'h77, 1'b0);
    applyStimulus(3'd7, 32'h0, 1'b0);
    applyStimulus(3'd6, 32'h0, 1'b0);
    setPointers(32'hFFFF_FFFF, BASE + 32'd3);
    applyStimulus(OP_CALL, 32'h300, 1'b0);
    applyStimulus(OP_POP, 32'h0, 1'b1);
    applyStimulus(OP_JUMP, 32'h1234_5678, 1'b0);
    resetMidPop();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0:       sp_r = BASE;
          1:       sp_r = LIMIT;
          2:       sp_r = LIMIT - 32'd1;
          3:       sp_r = BASE + 32'($urandom_range(1, 4));
          default: sp_r = BASE + 32'($urandom_range(0, DEPTH - 1));
        endcase
        setPointers(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, sp_r);
      end
      r    = $urandom_range(0, 15);
      op_r = (r < 14) ? 3'(r % 6) : 3'(6 + (r & 1));
      applyStimulus(op_r, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sp_sequencer.md
# pc_sp_sequencer

Sequencer that owns the program counter and stack pointer registers and the stack's memory port. It turns one-at-a-time control-flow requests (NEXT, JUMP, CALL, RET, PUSH, POP) into single-cycle increment/decrement/write strobes for the two pointer registers and read/write cycles on the stack RAM. It sits between the instruction decoder and the PC/SP pointer instances, with bounds checking on the stack region.

## Interface
- WIDTH, 32, pointer, address and data width
- STACK_BASE, 32'h0000_F000, lowest stack address; SP equal to this means empty
- STACK_LIMIT, 32'h0000_FFFF, SP equal to this means full; usable entries are STACK_BASE..STACK_LIMIT-1
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  1  request strobe, sampled only when READY=1
- OP  in  3  0 NEXT, 1 JUMP, 2 CALL, 3 RET, 4 PUSH, 5 POP, 6/7 illegal
- ARG  in  WIDTH  jump/call target or push data
- PC_IN, SP_IN  in  WIDTH  current PC / SP pointer values
- PC_INC, PC_WRITE  out  1  PC pointer strobes
- PC_NEWV  out  WIDTH  PC write value
- SP_INC, SP_DEC, SP_WRITE  out  1  SP pointer strobes (SP_WRITE held 0)
- SP_NEWV  out  WIDTH  held 0
- MEM_ADDR, MEM_WDATA  out  WIDTH  stack RAM address / write data
- MEM_WE, MEM_RE  out  1  stack RAM write / read enable
- MEM_RDATA  in  WIDTH  read data, valid the cycle after MEM_RE
- READY  out  1  high in IDLE only
- DONE  out  1  one-cycle completion pulse
- FAULT  out  1  qualifies DONE: request rejected
- FAULT_CAUSE  out  2  01 overflow, 10 underflow, 11 illegal op; valid with DONE
- RESULT  out  WIDTH  data from last successful POP/RET

## Operation
- States: IDLE, MEMW, MEMR, WAIT, UPD, FIN.
- IDLE: READY=1. On REQ, latch OP, ARG, PC_IN, SP_IN (snapshots used for the whole operation); pointer inputs are not re-sampled.
- Fault checks at accept: PUSH/CALL with SP==STACK_LIMIT is overflow; POP/RET with SP==STACK_BASE is underflow; OP 6/7 is illegal. A fault goes straight to FIN with FAULT=1: no memory access, no pointer strobe, RESULT unchanged.
- NEXT: UPD (PC_INC) -> FIN.
- JUMP: UPD (PC_WRITE, PC_NEWV=ARG) -> FIN.
- PUSH: MEMW (MEM_WE, ADDR=SP, WDATA=ARG) -> UPD (SP_INC) -> FIN.
- CALL: MEMW (MEM_WE, ADDR=SP, WDATA=PC+1 mod 2^WIDTH) -> UPD (SP_INC and PC_WRITE with ARG, same cycle) -> FIN.
- POP: MEMR (MEM_RE, ADDR=SP-1) -> WAIT (RESULT<=MEM_RDATA) -> UPD (SP_DEC) -> FIN.
- RET: as POP, but UPD also asserts PC_WRITE with PC_NEWV=RESULT.
- FIN: DONE=1 for one cycle, then IDLE. FAULT and FAULT_CAUSE are cleared on the next accepted request.
- Outputs are decoded from state and latched operands. All strobes, MEM_WE and MEM_RE are 0 outside their named state, and PC_NEWV, MEM_ADDR and MEM_WDATA are 0 when not in use.
- PC_INC and PC_WRITE are never asserted together. Neither are SP_INC and SP_DEC.
- REQ while READY=0 is ignored; there is no queue.

## Timing
- Accept on edge 0. DONE is high in cycle 2 for NEXT/JUMP, cycle 3 for PUSH/CALL, cycle 4 for POP/RET, and cycle 1 for any fault.
- Each strobe is high for exactly one cycle. The pointer value reflects the update by the next rising edge. The earliest next accept is the edge after FIN, so the next request sees the updated PC_IN and SP_IN.
- Reset, asynchronous: state IDLE, READY=1, and all strobes, MEM_WE, MEM_RE, DONE, FAULT, FAULT_CAUSE, RESULT and data outputs are 0.
- Reset mid-operation aborts immediately. A PUSH/CALL reset before UPD leaves SP unchanged, even if the RAM write already happened.
- The block never drives pointer strobes while RST_N=0.

## Test plan
- Reset, then NEXT with PC_IN=5 -> PC_INC pulse in cycle 1, DONE in cycle 2, no memory activity.
- PUSH ARG=0xAB with SP_IN=0xF000 -> cycle 1 MEM_WE=1, ADDR=0xF000, WDATA=0xAB; cycle 2 SP_INC; cycle 3 DONE, FAULT=0.
- CALL ARG=0x100 with PC_IN=0x20, SP_IN=0xF001, then RET with SP_IN=0xF002 and the RAM returning 0x21 -> CALL writes 0x21 at 0xF001; RET reads 0xF001, RESULT=0x21, PC_WRITE with 0x21 plus SP_DEC in cycle 3, DONE in cycle 4.
- POP with SP_IN=0xF000 -> DONE+FAULT in cycle 1, FAULT_CAUSE=10, no strobes. PUSH with SP_IN=0xFFFF -> FAULT_CAUSE=01. OP=7 -> FAULT_CAUSE=11.
- CALL with PC_IN=0xFFFF_FFFF -> WDATA=0. REQ held high during a busy POP -> exactly one DONE per accepted request.
- RST_N low during the WAIT state of POP -> all outputs 0 immediately, no SP_DEC, READY=1 after release.
